loop_ctrl: RTL

- Nested-loop iteration engine directly downstream of the instruction decoder.
- Stores per-loop iteration counts written by the decoder's `cfg_loop_iter_*` outputs.
- On the decoder's `loop_ctrl_start` pulse, walks the full nested iteration space, one point per unstalled cycle.
- Emits per-point step events that the address generators consume (init base / add stride of the stepping loop), then pulses `done` back to the decoder as `loop_ctrl_done`.

---
 rtl/loop_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/loop_ctrl.sv
// Purpose : nested-loop iteration engine; walks a configured loop nest and emits one step event per point.
// Latency : start sampled at t -> first point at t+1; done pulses the cycle after the last point is accepted.
// Backpr. : stall holds the current point (loop_index_v low, counters frozen); the point is re-presented on release.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cfg_loop_iter_v/_iter/_loop_id per-level iteration count write (iterations minus one), IDLE only
//   start, stall                   begin walking the nest; downstream backpressure
//   loop_index_v, loop_index       point accepted this cycle; loop level that stepped to reach it
//   loop_init, loop_last, done     first / final point of the nest; one-cycle completion pulse
module loop_ctrl #(
    parameter int NUM_MAX_LOOPS = 8,
    parameter int LOOP_ID_W     = 5,
    parameter int LOOP_ITER_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_loop_iter_v,
    input  logic [LOOP_ITER_W-1:0] cfg_loop_iter,
    input  logic [LOOP_ID_W-1:0]   cfg_loop_iter_loop_id,
    input  logic                   start,
    input  logic                   stall,
    output logic                   loop_index_v,
    output logic [LOOP_ID_W-1:0]   loop_index,
    output logic                   loop_init,
    output logic                   loop_last,
    output logic                   done
);

    localparam int IDX_W   = (NUM_MAX_LOOPS > 1) ? $clog2(NUM_MAX_LOOPS) : 1;
    localparam int DEPTH_W = $clog2(NUM_MAX_LOOPS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DEPTH_W-1:0]     depth_q, depth_d;
    logic [LOOP_ITER_W-1:0] iter_max_q [NUM_MAX_LOOPS];
    logic [LOOP_ITER_W-1:0] iter_max_d [NUM_MAX_LOOPS];
    logic [LOOP_ITER_W-1:0] counter_q  [NUM_MAX_LOOPS];
    logic [LOOP_ITER_W-1:0] counter_d  [NUM_MAX_LOOPS];
    // first_q marks that the presented point is the nest's first (no step yet)
    logic                   first_q, first_d;
    // idx_q is the level that stepped to reach the currently presented point
    logic [LOOP_ID_W-1:0]   idx_q, idx_d;

    logic                   cfg_id_ok;
    logic [IDX_W-1:0]       cfg_idx;
    logic [DEPTH_W-1:0]     cfg_depth;
    logic                   all_max;
    logic [IDX_W-1:0]       step_lvl;
    logic [LOOP_ID_W-1:0]   first_idx;
    logic                   busy;

    assign cfg_id_ok = (int'(cfg_loop_iter_loop_id) < NUM_MAX_LOOPS);
    assign cfg_idx   = cfg_loop_iter_loop_id[IDX_W-1:0];
    assign cfg_depth = DEPTH_W'(cfg_idx) + DEPTH_W'(1);
    assign first_idx = (depth_q == '0) ? '0 : LOOP_ID_W'(depth_q - DEPTH_W'(1));
    assign busy      = (state_q == ST_BUSY);

    // Innermost active level that has not reached its max is the one to step.
    // The compare happens before any increment, so a max of all-ones never wraps.
    always_comb begin
        all_max  = 1'b1;
        step_lvl = '0;
        for (int k = 0; k < NUM_MAX_LOOPS; k++) begin
            if (k < int'(depth_q) && counter_q[k] != iter_max_q[k]) begin
                all_max  = 1'b0;
                step_lvl = IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        iter_max_d = iter_max_q;
        counter_d  = counter_q;
        first_d    = first_q;
        idx_d      = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_loop_iter_v && cfg_id_ok) begin
                    iter_max_d[cfg_idx] = cfg_loop_iter;
                    if (cfg_depth > depth_q) begin
                        depth_d = cfg_depth;
                    end
                end
                if (start) begin
                    state_d = ST_BUSY;
                    first_d = 1'b1;
                    idx_d   = '0;
                    for (int k = 0; k < NUM_MAX_LOOPS; k++) begin
                        counter_d[k] = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (!stall) begin
                    if (all_max) begin
                        state_d = ST_DONE;
                    end else begin
                        first_d = 1'b0;
                        idx_d   = LOOP_ID_W'(step_lvl);
                        for (int k = 0; k < NUM_MAX_LOOPS; k++) begin
                            if (k == int'(step_lvl)) begin
                                counter_d[k] = counter_q[k] + LOOP_ITER_W'(1);
                            end else if (k > int'(step_lvl)) begin
                                counter_d[k] = '0;
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                // Configuration is single-use: the next nest must be written afresh.
                state_d = ST_IDLE;
                depth_d = '0;
                first_d = 1'b0;
                idx_d   = '0;
                for (int k = 0; k < NUM_MAX_LOOPS; k++) begin
                    iter_max_d[k] = '0;
                    counter_d[k]  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            depth_q <= '0;
            first_q <= 1'b0;
            idx_q   <= '0;
            for (int k = 0; k < NUM_MAX_LOOPS; k++) begin
                iter_max_q[k] <= '0;
                counter_q[k]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            first_q    <= first_d;
            idx_q      <= idx_d;
            iter_max_q <= iter_max_d;
            counter_q  <= counter_d;
        end
    end

    assign loop_index_v = busy && !stall;
    assign loop_init    = loop_index_v && first_q;
    assign loop_last    = loop_index_v && all_max;
    assign loop_index   = !loop_index_v ? '0 : (first_q ? first_idx : idx_q);
    assign done         = (state_q == ST_DONE);

endmodule
